shift_sequencer: RTL and testbench

Sequential front end for the combinational `full_shifter`: accepts one shift or rotate request at a time over a valid/ready handshake, drives the single `full_shifter` instance, registers the result, and holds it until downstream takes it. Rotates use two passes through the same shifter, so the ALU needs no second barrel shifter. Sits between the ALU operand/decode stage (upstream) and the ALU result mux (downstream).

---
 rtl/shift_sequencer_pkg.sv | 27 ++
 rtl/shift_sequencer_full_shifter.sv | 21 ++
 rtl/shift_sequencer.sv | 134 +++++++++++++
 tb/tb_shift_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared ALU definitions for the shift sequencer: widths, direction codes
// and the sequencer state encoding.
package shift_sequencer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned AMT_W  = 5;

  // Direction encoding shared with the full_shifter d input.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StShift = 3'd1,
    StRot1  = 3'd2,
    StRot2  = 3'd3,
    StDone  = 3'd4
  } seq_state_e;

  // Amount for the second rotate pass: (32 - amt) mod 32.
  function automatic logic [AMT_W-1:0] rot_back_amt(input logic [AMT_W-1:0] amt);
    logic [AMT_W-1:0] zero;
    zero = '0;
    return zero - amt;
  endfunction

endpackage

// File: rtl/shift_sequencer_full_shifter.sv
// Combinational logical barrel shifter, zero fill in both directions.
module full_shifter
  import shift_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic              d_i,
  input  logic [AMT_W-1:0]  s_i,
  output logic [WORD_W-1:0] y_o
);

  // Direction picks the shift operator; the amount never exceeds WORD_W-1.
  always_comb begin
    y_o = '0;
    if (d_i == DIR_LEFT) begin
      y_o = a_i << s_i;
    end else begin
      y_o = a_i >> s_i;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential front end for full_shifter: one shift/rotate request at a time
// over valid/ready, rotates done as two passes ORed together.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_dir,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_rot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result
);

  seq_state_e        state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              dir_q, dir_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              rot_q, rot_d;
  logic [WORD_W-1:0] partial_q, partial_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  logic [WORD_W-1:0] sh_a;
  logic              sh_d;
  logic [AMT_W-1:0]  sh_s;
  logic [WORD_W-1:0] sh_y;

  logic accept;

  assign in_ready   = (state_q == StIdle) && !reset;
  assign accept     = in_valid && in_ready;
  assign out_valid  = valid_q;
  assign out_result = result_q;

  // Shifter operand mux: second rotate pass goes the other way by 32-amt.
  always_comb begin
    sh_a = data_q;
    sh_d = dir_q;
    sh_s = amt_q;
    if (state_q == StRot2) begin
      sh_d = ~dir_q;
      sh_s = rot_back_amt(amt_q);
    end
  end

  full_shifter u_full_shifter (
    .a_i (sh_a),
    .d_i (sh_d),
    .s_i (sh_s),
    .y_o (sh_y)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    amt_d     = amt_q;
    rot_d     = rot_q;
    partial_d = partial_q;
    result_d  = result_q;
    valid_d   = valid_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d = in_data;
          dir_d  = in_dir;
          amt_d  = in_amt;
          rot_d  = in_rot;
          // A zero-amount rotate is the operand itself, so a single pass suffices.
          if (in_rot && (in_amt != '0)) begin
            state_d = StRot1;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        result_d = sh_y;
        valid_d  = 1'b1;
        state_d  = StDone;
      end
      StRot1: begin
        partial_d = sh_y;
        state_d   = StRot2;
      end
      StRot2: begin
        result_d = sh_y | (rot_q ? partial_q : '0);
        valid_d  = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      dir_q     <= DIR_LEFT;
      amt_q     <= '0;
      rot_q     <= 1'b0;
      partial_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      amt_q     <= amt_d;
      rot_q     <= rot_d;
      partial_q <= partial_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed results.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_dir;
  logic [4:0]  in_amt;
  logic        in_rot;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int n_checks;
  int n_fails;

  shift_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .in_amt     (in_amt),
    .in_rot     (in_rot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for out_valid, check latency and result.
  // Leaves the bench at the negedge where out_valid was first seen.
  task automatic run_req(input string tag, input logic [31:0] data, input logic dir,
                         input logic [4:0] amt, input logic rot, input int exp_lat,
                         input logic [31:0] exp_res);
    int lat;
    in_valid = 1'b1;
    in_data  = data;
    in_dir   = dir;
    in_amt   = amt;
    in_rot   = rot;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 32'hA5A5_5A5A;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_result"}, out_result, exp_res);
  endtask

  // With out_ready high, one edge returns to IDLE; result must be held.
  task automatic finish_req(input string tag, input logic [31:0] exp_res);
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_held"}, out_result, exp_res);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_amt    = '0;
    in_rot    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clock);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_result", out_result, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);

    run_req("shl4", 32'h0000_00F1, 1'b0, 5'd4, 1'b0, 2, 32'h0000_0F10);
    finish_req("shl4", 32'h0000_0F10);

    run_req("shr31", 32'h8000_0000, 1'b1, 5'd31, 1'b0, 2, 32'h0000_0001);
    finish_req("shr31", 32'h0000_0001);

    run_req("rotr8", 32'h1234_5678, 1'b1, 5'd8, 1'b1, 3, 32'h7812_3456);
    finish_req("rotr8", 32'h7812_3456);

    run_req("rot0", 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 2, 32'hDEAD_BEEF);
    finish_req("rot0", 32'hDEAD_BEEF);

    run_req("rotl1", 32'h8000_0001, 1'b0, 5'd1, 1'b1, 3, 32'h0000_0003);
    finish_req("rotl1", 32'h0000_0003);

    run_req("shr0", 32'hCAFE_F00D, 1'b1, 5'd0, 1'b0, 2, 32'hCAFE_F00D);
    finish_req("shr0", 32'hCAFE_F00D);

    // Backpressure: result held, new requests ignored while DONE.
    out_ready = 1'b0;
    run_req("bp", 32'hF000_000F, 1'b0, 5'd4, 1'b1, 3, 32'h0000_00FF);
    in_valid = 1'b1;
    in_data  = 32'h1111_1111;
    in_rot   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_result", out_result, 32'h0000_00FF);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_req("bp", 32'h0000_00FF);
    run_req("after_bp", 32'h0000_0001, 1'b0, 5'd31, 1'b0, 2, 32'h8000_0000);
    finish_req("after_bp", 32'h8000_0000);

    // Reset during ROT2 discards the request.
    in_valid = 1'b1;
    in_data  = 32'h0F0F_0F0F;
    in_dir   = 1'b1;
    in_amt   = 5'd4;
    in_rot   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mid_result", out_result, 32'd0);
    check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_eq("no_stale_valid", {31'd0, out_valid}, 32'd0);
      check_eq("no_stale_result", out_result, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
